// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO.
//
// A processor store to ADDR_DATA queues WriteData[7:0]. The FSM drains the
// FIFO one frame at a time: start bit, 8 data bits LSB first, stop bit. Each
// bit lasts BAUD_DIV clocks. Frames are sent back to back with no idle gap
// while bytes remain queued. A push into a full FIFO is dropped and sets a
// sticky overflow flag. A store of bit0=1 to ADDR_STAT clears that flag.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   MemWrite   store strobe
//   Adr        byte address of the access
//   WriteData  store data
//   ReadData   status word when Adr==ADDR_STAT, else 0 (combinational)
//   hit        Adr decodes to one of this block's two registers
//   tx         serial line (registered, idles high)
//   busy       frame in progress or bytes still queued
module mmio_uart_tx #(
    parameter int          BAUD_DIV  = 4,
    parameter logic [31:0] ADDR_DATA = 32'h80,
    parameter logic [31:0] ADDR_STAT = 32'h84
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nx;
    logic [7:0]  fifo [4];
    logic [1:0]  wptr, rptr;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  shift;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;

    logic        push, accept, clr_ovf, bit_end;
    logic        pop, bit_entry, shift_adv, tx_nx;
    logic        unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign push    = MemWrite && (Adr == ADDR_DATA);
    assign clr_ovf = MemWrite && (Adr == ADDR_STAT) && WriteData[0];
    assign bit_end = (baud_cnt == 16'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept  = push && ((count != 3'd4) || pop);

    assign hit      = (Adr == ADDR_DATA) || (Adr == ADDR_STAT);
    assign busy     = (state != IDLE) || (count != 3'd0);
    assign ReadData = (Adr == ADDR_STAT)
                    ? {25'd0, count, overflow, (state != IDLE), (count == 3'd0), (count == 3'd4)}
                    : 32'd0;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (count != 3'd0) state_nx = START;
            START: if (bit_end) state_nx = DATA;
            DATA:  if (bit_end && (bit_idx == 3'd7)) state_nx = STOP;
            STOP:  if (bit_end) state_nx = (count != 3'd0) ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output / control logic; tx is computed for the state being entered so
    // the registered line changes on the same edge as the state.
    always_comb begin
        pop       = ((state == IDLE) || ((state == STOP) && bit_end)) && (count != 3'd0);
        bit_entry = (state_nx != state) || ((state == DATA) && bit_end);
        shift_adv = (state == DATA) && bit_end && (bit_idx != 3'd7);
        tx_nx     = 1'b1;
        case (state_nx)
            IDLE:  tx_nx = 1'b1;
            START: tx_nx = 1'b0;
            DATA:  tx_nx = shift_adv ? shift[1] : shift[0];
            STOP:  tx_nx = 1'b1;
            default: tx_nx = 1'b1;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx       <= 1'b1;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            tx <= tx_nx;

            if (bit_entry)           baud_cnt <= RELOAD;
            else if (!bit_end)       baud_cnt <= baud_cnt - 16'd1;

            if (state == START)      bit_idx <= 3'd0;
            else if (shift_adv)      bit_idx <= bit_idx + 3'd1;

            if (accept) wptr <= wptr + 2'd1;
            if (pop)    rptr <= rptr + 2'd1;

            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (clr_ovf)             overflow <= 1'b0;
            else if (push && !accept) overflow <= 1'b1;
        end
    end

    // Datapath registers (no reset needed; contents are qualified by count/state)
    always_ff @(posedge clk) begin
        if (accept)         fifo[wptr] <= WriteData[7:0];
        if (pop)            shift <= fifo[rptr];
        else if (shift_adv) shift <= {1'b0, shift[7:1]};
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int          B    = 4;
    localparam logic [31:0] ADAT = 32'h80;
    localparam logic [31:0] ASTA = 32'h84;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        hit, tx, busy;

    mmio_uart_tx #(.BAUD_DIV(B), .ADDR_DATA(ADAT), .ADDR_STAT(ASTA)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr),
        .WriteData(WriteData), .ReadData(ReadData), .hit(hit), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending byte queue, the frame on the line as a
    // 10-bit pattern, and cycles remaining in that frame.
    logic [7:0]  mq[$];
    logic [9:0]  frame = 10'h3FF;
    int          rem = 0;
    logic        movf = 1'b0;

    logic [31:0] cap_rd, exp_rd;
    logic        cap_hit, exp_hit;

    function automatic logic exp_tx();
        if (rem > 0) return frame[(10*B - rem) / B];
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (rem > 0) || (mq.size() > 0);
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] r;
        int sz;
        sz = mq.size();
        r = 32'h0;
        r[0] = (sz == 4);
        r[1] = (sz == 0);
        r[2] = (rem > 0);
        r[3] = movf;
        r[6:4] = 3'(sz);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        rem = 0;
        frame = 10'h3FF;
        movf = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        int sz;
        bit pop;
        logic [7:0] b;
        sz = mq.size();
        pop = (rem <= 1) && (sz > 0);
        if (pop) begin
            b = mq.pop_front();
            frame = {1'b1, b, 1'b0};
            rem = 10 * B;
        end else if (rem > 0) begin
            rem--;
        end
        if (we && a == ADAT) begin
            if (sz < 4 || pop) mq.push_back(d[7:0]);
            else movf = 1'b1;
        end
        if (we && a == ASTA && d[0]) movf = 1'b0;
    endtask

    // Drive one cycle: settle inputs, capture combinational outputs and
    // their expected values, clock, advance the model, sample after the edge.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite = we; Adr = a; WriteData = d;
        #2;
        cap_rd  = ReadData;
        cap_hit = hit;
        exp_rd  = (a == ASTA) ? exp_status() : 32'h0;
        exp_hit = (a == ADAT) || (a == ASTA);
        @(posedge clk);
        model_edge(we, a, d);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; MemWrite = 1'b0; Adr = ASTA;
        model_reset();
        #12;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL reset_status got=%h exp=00000002", ReadData); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit got=%b exp=1", hit); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, ADAT, 32'hDEAD_BEA5);
        for (int i = 0; i < 46; i++) begin
            checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy()); end
            step(1'b0, 32'h0, 32'h0);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done busy=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, ADAT, 32'h01);
        step(1'b1, ADAT, 32'h02);
        for (int i = 0; i < 90; i++) begin
            checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy()); end
            step(1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) step(1'b1, ADAT, 32'h10 + i);
        step(1'b0, ASTA, 32'h0);
        checks++; if (cap_rd[3] !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", cap_rd[3]); end
        checks++; if (cap_rd[6:4] !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", cap_rd[6:4]); end
        for (int i = 0; i < 215; i++) begin
            checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL ovf_tx cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
            checks++; if (cap_rd !== exp_rd) begin errors++; $display("FAIL ovf_status cyc=%0d got=%h exp=%h", i, cap_rd, exp_rd); end
            step(1'b0, ASTA, 32'h0);
        end
        step(1'b1, ASTA, 32'hFFFF_FFF1);
        step(1'b0, ASTA, 32'h0);
        checks++; if (cap_rd[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", cap_rd[3]); end
        checks++; if (cap_rd !== 32'h2) begin errors++; $display("FAIL ovf_idle_status got=%h exp=00000002", cap_rd); end
    endtask

    task automatic test_status();
        step(1'b1, ADAT, 32'hAA);
        step(1'b1, ADAT, 32'hBB);
        step(1'b0, ASTA, 32'h0);
        checks++; if (cap_rd !== 32'h14) begin errors++; $display("FAIL status_busy got=%h exp=00000014", cap_rd); end
        checks++; if (cap_hit !== 1'b1) begin errors++; $display("FAIL status_hit got=%b exp=1", cap_hit); end
        step(1'b0, 32'h60, 32'h0);
        checks++; if (cap_rd !== 32'h0) begin errors++; $display("FAIL status_other got=%h exp=00000000", cap_rd); end
        checks++; if (cap_hit !== 1'b0) begin errors++; $display("FAIL status_other_hit got=%b exp=0", cap_hit); end
        for (int i = 0; i < 85; i++) begin
            checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL status_tx cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
            step(1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, ADAT, 32'h3C);
        step(1'b1, ADAT, 32'h5A);
        // now 1 cycle into the frame; advance into data bit 3
        for (int i = 0; i < 17; i++) step(1'b0, 32'h0, 32'h0);
        checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL mid_pre_tx got=%b exp=%b", tx, exp_tx()); end
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        step(1'b0, ASTA, 32'h0);
        checks++; if (cap_rd !== 32'h2) begin errors++; $display("FAIL mid_status got=%h exp=00000002", cap_rd); end
        for (int i = 0; i < 60; i++) begin
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_residual cyc=%0d got=%b exp=1", i, tx); end
            step(1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_ignored();
        step(1'b1, 32'h64, 32'h7);
        checks++; if (cap_hit !== 1'b0) begin errors++; $display("FAIL ign_hit got=%b exp=0", cap_hit); end
        step(1'b0, ASTA, 32'h0);
        checks++; if (cap_rd !== 32'h2) begin errors++; $display("FAIL ign_status got=%h exp=00000002", cap_rd); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL ign_tx cyc=%0d got=%b exp=1", i, tx); end
            step(1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic test_random();
        int r;
        logic [31:0] a, d;
        logic we;
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            d = $urandom;
            if (r < 7) begin
                we = 1'b1; a = ADAT;
            end else if (r < 9) begin
                we = 1'b1; a = ASTA;
            end else if (r < 45) begin
                we = 1'b0; a = ASTA;
            end else begin
                we = $urandom_range(0, 1) == 1;
                a = $urandom & 32'hFC;
            end
            step(we, a, d);
            checks++; if (cap_rd !== exp_rd) begin errors++; $display("FAIL rnd_status cyc=%0d got=%h exp=%h", i, cap_rd, exp_rd); end
            checks++; if (cap_hit !== exp_hit) begin errors++; $display("FAIL rnd_hit cyc=%0d got=%b exp=%b", i, cap_hit, exp_hit); end
            checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL rnd_tx cyc=%0d got=%b exp=%b", i, tx, exp_tx()); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_status();
        test_reset_midframe();
        test_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
